sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_pkg.sv | 9 +
 rtl/sram_fifo_ctrl_if.sv | 26 ++
 rtl/sram_fifo_obuf.sv | 60 ++++++
 rtl/sram_fifo_ctrl.sv | 99 +++++++++
 tb/tb_sram_fifo_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared defaults for the SRAM-backed FIFO controller: geometry and the fixed RAM write mask.
package sram_fifo_pkg;
    localparam int DEF_DEPTH  = 2048;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_CNT_W  = 12;

    localparam logic [1:0] MEM_W_MASK = 2'b11;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Enqueue/dequeue handshake bundle of the SRAM FIFO plus its occupancy count.
// Handshake: a transfer fires on a side in a cycle where valid and ready are both high at the rising edge.
interface sram_fifo_ctrl_if
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [CNT_W-1:0] count;

    modport slave (
        input  enq_valid, enq_bits, deq_ready,
        output enq_ready, deq_valid, deq_bits, count
    );

    modport master (
        output enq_valid, enq_bits, deq_ready,
        input  enq_ready, deq_valid, deq_bits, count
    );
endinterface

// File: rtl/sram_fifo_obuf.sv
// Two-entry output buffer in front of the RAM; head is a flop so deq_bits has no logic behind it.
module sram_fifo_obuf
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       cnt,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever survives the pop.
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign head = head_q;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// Ready/valid FIFO on an external two-port sync-read RAM with a 2-entry output buffer.
// Optional SRAM_FIFO_BYPASS_EN: when the RAM path is empty, enqueued words go straight to the buffer.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    sram_fifo_ctrl_if.slave   io,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [WIDTH-1:0]  mem_r_data,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [WIDTH-1:0]  mem_w_data,
    output logic [1:0]        mem_w_mask
);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        buf_cnt;
    logic [WIDTH-1:0]  buf_head;
    logic              enq_fire, deq_fire, bypass, ram_wr, rd_issue, buf_push;
    logic [2:0]        occ_after;
    logic [WIDTH-1:0]  push_data;

    always_comb begin
        io.enq_ready = (ram_cnt_q < DEPTH_C);
        io.deq_valid = (buf_cnt != 2'd0);
        io.deq_bits  = buf_head;
        io.count     = ram_cnt_q + CNT_W'(inflight_q) + CNT_W'(buf_cnt);

        enq_fire  = io.enq_valid & io.enq_ready;
        deq_fire  = io.deq_valid & io.deq_ready;
        // Buffer slots still claimed after this cycle's pop, counting a read already on its way.
        occ_after = 3'(buf_cnt) + 3'(inflight_q) - 3'(deq_fire);
`ifdef SRAM_FIFO_BYPASS_EN
        bypass    = enq_fire & (ram_cnt_q == '0) & ~inflight_q & (occ_after < 3'd2);
`else
        bypass    = 1'b0;
`endif
        // Writes are suppressed while reset is held so no RAM location is touched during reset.
        ram_wr    = enq_fire & ~bypass & reset_n;
        // Only words counted in ram_cnt_q (committed at earlier edges) are ever read.
        rd_issue  = (ram_cnt_q != '0) & (occ_after <= 3'd1);

        buf_push  = inflight_q | bypass;
        push_data = inflight_q ? mem_r_data : io.enq_bits;

        wr_ptr_d   = ram_wr   ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = rd_issue ? next_ptr(rd_ptr_q) : rd_ptr_q;
        ram_cnt_d  = ram_cnt_q + CNT_W'(ram_wr) - CNT_W'(rd_issue);
        inflight_d = rd_issue;

        mem_w_en   = ram_wr;
        mem_w_addr = wr_ptr_q;
        mem_w_data = io.enq_bits;
        mem_w_mask = MEM_W_MASK;
        mem_r_en   = rd_issue;
        mem_r_addr = rd_ptr_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    sram_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (buf_push),
        .push_data (push_data),
        .pop       (deq_fire),
        .cnt       (buf_cnt),
        .head      (buf_head)
    );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: 2048x4 sync-read RAM model, queue-based reference, directed and random traffic.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  localparam int DEPTH  = DEF_DEPTH;
  localparam int WIDTH  = DEF_WIDTH;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int CNT_W  = DEF_CNT_W;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int STEADY_CNT = 1;
`else
  localparam int STEADY_CNT = 3;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sram_fifo_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) io ();

  logic              mem_r_en, mem_w_en;
  logic [ADDR_W-1:0] mem_r_addr, mem_w_addr;
  logic [WIDTH-1:0]  mem_r_data, mem_w_data;
  logic [1:0]        mem_w_mask;

  sram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .io         (io.slave),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_w_mask (mem_w_mask)
  );

  // 2048x4 synchronous-read RAM
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= ram[mem_r_addr];
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  int exp_waddr = 0;
  int exp_raddr = 0;
  int wr_total = 0;
  int rd_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_waddr = 0;
      exp_raddr = 0;
      wr_total  = 0;
      rd_total  = 0;
      chk("rst_count", int'(io.count), 0);
      chk("rst_deq_valid", int'(io.deq_valid), 0);
      chk("rst_mem_r_en", int'(mem_r_en), 0);
      chk("rst_mem_w_en", int'(mem_w_en), 0);
      chk("rst_enq_ready", int'(io.enq_ready), 1);
    end else begin
      chk("count", int'(io.count), exp_q.size());
      if (exp_q.size() == 0) chk("deq_valid_when_empty", int'(io.deq_valid), 0);
      if (exp_q.size() < DEPTH) chk("enq_ready_with_room", int'(io.enq_ready), 1);
      if (exp_q.size() == DEPTH + 2) chk("enq_ready_when_full", int'(io.enq_ready), 0);
      chk("w_mask", int'(mem_w_mask), 3);
`ifdef SRAM_FIFO_BYPASS_EN
      if (mem_w_en) chk("w_en_needs_fire", int'(io.enq_valid && io.enq_ready), 1);
`else
      chk("w_en_eq_fire", int'(mem_w_en), int'(io.enq_valid && io.enq_ready));
`endif
      if (mem_r_en) begin
        chk("r_addr", int'(mem_r_addr), exp_raddr);
        chk("read_committed_only", int'(rd_total < wr_total), 1);
        if (mem_w_en) chk("rw_same_addr", int'(mem_r_addr != mem_w_addr), 1);
        exp_raddr = (exp_raddr + 1) % DEPTH;
        rd_total++;
      end
      if (mem_w_en) begin
        chk("w_data", int'(mem_w_data), int'(io.enq_bits));
        chk("w_addr", int'(mem_w_addr), exp_waddr);
        exp_waddr = (exp_waddr + 1) % DEPTH;
        wr_total++;
      end
      if (io.deq_valid && io.deq_ready) begin
        if (exp_q.size() == 0) chk("deq_underflow", 1, 0);
        else chk("deq_bits", int'(io.deq_bits), int'(exp_q.pop_front()));
      end
      if (io.enq_valid && io.enq_ready) exp_q.push_back(io.enq_bits);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq_one(input logic [WIDTH-1:0] d);
    int n = 0;
    io.enq_valid = 1'b1;
    io.enq_bits  = d;
    @(negedge clock);
    while (!io.enq_ready && n < 100) begin
      step();
      @(negedge clock);
      n++;
    end
    if (!io.enq_ready) chk("enq_timeout", 0, 1);
    step();
  endtask

  task automatic wait_empty();
    int n = 0;
    while (io.count != '0 && n < 5000) begin
      step();
      n++;
    end
    @(negedge clock);
    chk("drain_to_empty", int'(io.count), 0);
    step();
  endtask

  initial begin
    io.enq_valid = 1'b0;
    io.enq_bits  = '0;
    io.deq_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // single word latency from empty
    io.deq_ready = 1'b1;
    io.enq_valid = 1'b1;
    io.enq_bits  = 4'hA;
    @(negedge clock);
`ifdef SRAM_FIFO_BYPASS_EN
    chk("s1_c0_w_en", int'(mem_w_en), 0);
    step();
    io.enq_valid = 1'b0;
    @(negedge clock);
    chk("s1_c1_deq_valid", int'(io.deq_valid), 1);
    chk("s1_c1_deq_bits", int'(io.deq_bits), 10);
`else
    chk("s1_c0_w_en", int'(mem_w_en), 1);
    chk("s1_c0_w_addr", int'(mem_w_addr), 0);
    step();
    io.enq_valid = 1'b0;
    @(negedge clock);
    chk("s1_c1_r_en", int'(mem_r_en), 1);
    chk("s1_c1_deq_valid", int'(io.deq_valid), 0);
    step();
    @(negedge clock);
    chk("s1_c2_deq_valid", int'(io.deq_valid), 0);
    step();
    @(negedge clock);
    chk("s1_c3_deq_valid", int'(io.deq_valid), 1);
    chk("s1_c3_deq_bits", int'(io.deq_bits), 10);
`endif
    wait_empty();

    // fill to capacity with the output stalled, then drain in order
    io.deq_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) enq_one(WIDTH'(i));
    io.enq_bits = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("s2_full_enq_ready", int'(io.enq_ready), 0);
      chk("s2_full_count", int'(io.count), 2050);
      step();
    end
    io.enq_valid = 1'b0;
    io.deq_ready = 1'b1;
    wait_empty();

    // streaming with both sides always ready
    io.enq_valid = 1'b1;
    io.deq_ready = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      io.enq_bits = WIDTH'($urandom_range(0, 15));
      @(negedge clock);
      if (c >= 4) begin
        chk("s3_deq_valid", int'(io.deq_valid), 1);
        chk("s3_count", int'(io.count), STEADY_CNT);
      end
      step();
    end
    io.enq_valid = 1'b0;
    wait_empty();

    // reset with a RAM read in flight
    io.deq_ready = 1'b0;
    for (int i = 1; i <= 7; i++) enq_one(WIDTH'(i));
    io.enq_valid = 1'b0;
    repeat (4) step();
    @(negedge clock);
    chk("s4_count_7", int'(io.count), 7);
    step();
    io.deq_ready = 1'b1;
    io.enq_valid = 1'b1;
    io.enq_bits  = 4'h8;
    @(negedge clock);
    chk("s4_r_en", int'(mem_r_en), 1);
    step();
    io.deq_ready = 1'b0;
    io.enq_valid = 1'b0;
    @(negedge clock);
    chk("s4_count_before_reset", int'(io.count), 7);
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("s4_reset_count", int'(io.count), 0);
    chk("s4_reset_deq_valid", int'(io.deq_valid), 0);
    step();
    reset_n = 1'b1;
    enq_one(4'h5);
    io.enq_valid = 1'b0;
    io.deq_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clock);
      while (!io.deq_valid && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("s4_first_after_reset_valid", int'(io.deq_valid), 1);
      chk("s4_first_after_reset_bits", int'(io.deq_bits), 5);
    end
    step();
    wait_empty();

    // random traffic with 30% dequeue stalls
    for (int c = 0; c < 3000; c++) begin
      io.enq_valid = ($urandom_range(0, 99) < 75);
      io.enq_bits  = WIDTH'($urandom_range(0, 15));
      io.deq_ready = ($urandom_range(0, 99) >= 30);
      step();
    end
    io.enq_valid = 1'b0;
    io.deq_ready = 1'b1;
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
